// File: rtl/audio_pkg.sv
// Types and constants shared by the audio capture and playback paths.
// The sound-region map must stay in step with the playback ROM layout.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FINISH
  } state_t;

  localparam int SAMPLE_W = 6;
  localparam int ADDR_W   = 18;

  localparam int WIN_BASE    = 0;
  localparam int WIN_LAST    = 16395;
  localparam int MOO_BASE    = 16396;
  localparam int MOO_LAST    = 66982;
  localparam int DETECT_BASE = 66983;
  localparam int DETECT_LAST = 83254;
  localparam int CHEER_BASE  = 83255;
  localparam int CHEER_LAST  = 137138;

  // One extra bit so that the most negative sample (-32) yields +32.
  function automatic logic [SAMPLE_W:0] sample_mag(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W:0] ext;
    ext = {s[SAMPLE_W-1], s};
    return s[SAMPLE_W-1] ? (~ext + 1'b1) : ext;
  endfunction

endpackage

// File: rtl/audio_peak_tracker.sv
// Running maximum of |sample| for two's-complement samples.
// Clear has priority over enable.
module audio_peak_tracker
  import audio_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] peak_o
);

  logic [SAMPLE_W:0]   mag;
  logic [SAMPLE_W-1:0] mag_sat;
  logic [SAMPLE_W-1:0] peak_d;
  logic [SAMPLE_W-1:0] peak_q;

  assign mag     = sample_mag(sample_i);
  assign mag_sat = mag[SAMPLE_W] ? SAMPLE_W'(32) : mag[SAMPLE_W-1:0];

  always_comb begin
    peak_d = peak_q;
    if (clear_i) begin
      peak_d = '0;
    end else if (en_i && (mag_sat > peak_q)) begin
      peak_d = mag_sat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/audio_capture_writer.sv
// Drains the audio-in FIFO, decimates left-channel samples and writes the
// top 6 bits of each kept sample to sound RAM at consecutive addresses.
module audio_capture_writer
  import audio_pkg::*;
#(
  parameter int DEPTH = 16396,
  parameter int DECIM = 4
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic                audio_in_available,
  input  logic [31:0]         left_channel_audio_in,
  output logic                read_audio_in,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_data,
  output logic                mem_we,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   sample_count,
  output logic [SAMPLE_W-1:0] peak_level
);

  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t              state_q;
  logic [DEC_W-1:0]    dec_q;
  logic [DEC_W-1:0]    dec_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [SAMPLE_W-1:0] data_q;
  logic                we_q;
  logic                done_q;
  logic [ADDR_W-1:0]   count_q;

  logic                accept;
  logic                keep;
  logic                last_word;
  logic                begin_capture;
  logic [SAMPLE_W-1:0] sample;
  logic                unused_low_bits;

  assign sample          = left_channel_audio_in[31:26];
  assign unused_low_bits = ^left_channel_audio_in[25:0];

  // Every sample present is popped; only those in CAPTURE are used.
  assign read_audio_in = audio_in_available;
  assign accept        = (state_q == CAPTURE) && audio_in_available;
  assign keep          = accept && (dec_q == '0);
  assign last_word     = (count_q == ADDR_W'(DEPTH - 1));
  assign begin_capture = (state_q == IDLE) && start && !abort;
  assign dec_d         = (dec_q == DEC_W'(DECIM - 1)) ? '0 : dec_q + 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      dec_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (begin_capture) begin
            count_q <= '0;
            dec_q   <= '0;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (accept) begin
            dec_q <= dec_d;
          end
          if (keep) begin
            addr_q  <= count_q;
            data_q  <= sample;
            we_q    <= 1'b1;
            count_q <= count_q + 1'b1;
          end
          // Abort lets an in-flight write land but suppresses completion.
          if (abort) begin
            state_q <= IDLE;
          end else if (keep && last_word) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  audio_peak_tracker u_peak (
    .clk_i    (CLOCK_50),
    .rst_ni   (resetn),
    .clear_i  (begin_capture),
    .en_i     (accept),
    .sample_i (sample),
    .peak_o   (peak_level)
  );

  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_we       = we_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign sample_count = count_q;

endmodule

// File: tb/tb_audio_capture_writer.sv
// Randomised and directed bench for two capture writers (DECIM=2 and DECIM=1)
// sharing one input stream, checked against a transaction-level model.
module tb_audio_capture_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic        av;
  logic [31:0] left;

  logic        o_rd   [2];
  logic [17:0] o_addr [2];
  logic [5:0]  o_data [2];
  logic        o_we   [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic [17:0] o_cnt  [2];
  logic [5:0]  o_peak [2];

  always #5 clk = ~clk;

  audio_capture_writer #(.DEPTH(DEPTH), .DECIM(2)) u_dut2 (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .abort(abort),
    .audio_in_available(av), .left_channel_audio_in(left),
    .read_audio_in(o_rd[0]), .mem_addr(o_addr[0]), .mem_data(o_data[0]),
    .mem_we(o_we[0]), .busy(o_busy[0]), .done(o_done[0]),
    .sample_count(o_cnt[0]), .peak_level(o_peak[0])
  );

  audio_capture_writer #(.DEPTH(DEPTH), .DECIM(1)) u_dut1 (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .abort(abort),
    .audio_in_available(av), .left_channel_audio_in(left),
    .read_audio_in(o_rd[1]), .mem_addr(o_addr[1]), .mem_data(o_data[1]),
    .mem_we(o_we[1]), .busy(o_busy[1]), .done(o_done[1]),
    .sample_count(o_cnt[1]), .peak_level(o_peak[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model: capturing flag, accepted-sample index, write list.
  int decim_of [2] = '{2, 1};
  int m_mode [2];   // 0 idle, 1 capturing, 2 finishing
  int m_acc  [2];
  int m_cnt  [2];
  int m_peak [2];
  int m_addr [2];
  int m_data [2];
  int m_we   [2];
  int m_done [2];

  int done_seen [2];
  int run_cur, run_max;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int s, mag;
    if (!resetn) begin
      m_mode[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_peak[k] = 0;
      m_addr[k] = 0; m_data[k] = 0; m_we[k] = 0; m_done[k] = 0;
      return;
    end
    m_we[k] = 0;
    m_done[k] = 0;
    if (m_mode[k] == 0) begin
      if (start && !abort) begin
        m_mode[k] = 1; m_acc[k] = 0; m_cnt[k] = 0; m_peak[k] = 0;
      end
    end else if (m_mode[k] == 2) begin
      m_mode[k] = 0;
    end else begin
      if (av) begin
        s   = int'(left[31:26]);
        if (s >= 32) s = s - 64;
        mag = (s < 0) ? -s : s;
        if (mag > m_peak[k]) m_peak[k] = mag;
        if (m_acc[k] % decim_of[k] == 0) begin
          m_addr[k] = m_cnt[k];
          m_data[k] = int'(left[31:26]);
          m_we[k]   = 1;
          m_cnt[k]  = m_cnt[k] + 1;
        end
        m_acc[k] = m_acc[k] + 1;
      end
      if (abort) begin
        m_mode[k] = 0;
      end else if (m_we[k] == 1 && m_cnt[k] == DEPTH) begin
        m_mode[k] = 2;
        m_done[k] = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rd%0d", k), int'(o_rd[k]), int'(av));
      check_eq($sformatf("we%0d", k), int'(o_we[k]), m_we[k]);
      check_eq($sformatf("done%0d", k), int'(o_done[k]), m_done[k]);
      check_eq($sformatf("busy%0d", k), int'(o_busy[k]), int'(m_mode[k] != 0));
      check_eq($sformatf("cnt%0d", k), int'(o_cnt[k]), m_cnt[k]);
      check_eq($sformatf("peak%0d", k), int'(o_peak[k]), m_peak[k]);
      if (m_we[k] == 1 || !resetn) begin
        check_eq($sformatf("addr%0d", k), int'(o_addr[k]), m_addr[k]);
        check_eq($sformatf("data%0d", k), int'(o_data[k]), m_data[k]);
      end
      if (o_done[k] === 1'b1) done_seen[k]++;
    end
    if (o_we[1] === 1'b1) begin
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
    end else begin
      run_cur = 0;
    end
  endtask

  task automatic set_sample(input logic [5:0] s6);
    logic [31:0] r;
    r = $urandom();
    left = {s6, r[25:0]};
  endtask

  // Sample offered on every third cycle.
  task automatic feed(input logic [5:0] s6);
    av = 1'b0; tick();
    av = 1'b0; tick();
    av = 1'b1; set_sample(s6); tick();
    av = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    int reached;
    logic [5:0] v;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; av = 1'b0; left = '0;
    run_cur = 0; run_max = 0;
    done_seen = '{0, 0};
    tick(); tick();
    check_eq("rst_busy", int'(o_busy[0]), 0);
    resetn = 1'b1;
    tick();

    // Full capture of 1..16 with DECIM=2 -> odd values at 0..7.
    pulse_start();
    for (int i = 1; i <= 16; i++) begin
      v = 6'(i);
      feed(v);
    end
    tick(); tick();
    check_eq("done_once", done_seen[0], 1);
    check_eq("full_cnt", int'(o_cnt[0]), 8);

    // Peak tracking with the most negative code.
    pulse_start();
    feed(6'b100000);
    feed(6'b011111);
    feed(6'b000101);
    check_eq("peak32", int'(o_peak[0]), 32);

    // Abort once three words are written.
    reached = 0;
    for (int i = 0; i < 20 && reached == 0; i++) begin
      if (m_cnt[0] == 3) reached = 1;
      else feed(6'($urandom()));
    end
    check_eq("reach3", reached, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("abort_busy", int'(o_busy[0]), 0);
    check_eq("abort_cnt", int'(o_cnt[0]), 3);
    for (int i = 0; i < 3; i++) feed(6'($urandom()));

    // Start together with abort is refused.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_eq("sa_idle", int'(o_busy[0]), 0);

    // Start while busy is ignored; then reset mid-capture at count 3.
    pulse_start();
    feed(6'($urandom()));
    start = 1'b1; feed(6'($urandom())); start = 1'b0;
    reached = 0;
    for (int i = 0; i < 20 && reached == 0; i++) begin
      if (m_cnt[0] == 3) reached = 1;
      else feed(6'($urandom()));
    end
    check_eq("reach3b", reached, 1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    check_eq("rst_mid_cnt", int'(o_cnt[0]), 0);

    // DECIM=1 with FIFO always non-empty: eight back-to-back writes.
    pulse_start();
    run_cur = 0; run_max = 0;
    av = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_sample(6'($urandom()));
      tick();
    end
    av = 1'b0;
    check_eq("burst_run", run_max, 8);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      resetn = ($urandom_range(0, 99) != 0);
      start  = ($urandom_range(0, 11) == 0);
      abort  = ($urandom_range(0, 39) == 0);
      av     = ($urandom_range(0, 1) == 1);
      set_sample(6'($urandom()));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
